// File: rtl/en_pulse_gen_pkg.sv
// Shared types and constants for the enable-pulse generator.
// Optional SVA checks in the top are enabled with EN_PULSE_GEN_ASSERTS_EN.
package en_pulse_gen_pkg;

  localparam int DEF_DIV_W   = 16;
  localparam int DEF_BURST_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/en_pulse_gen_if.sv
// Control/status bundle between a sequencer (master) and the pulse generator (slave).
interface en_pulse_gen_if
  import en_pulse_gen_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int BURST_W = DEF_BURST_W
) ();

  logic               start;
  logic               stop;
  logic               mode;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst_len;
  logic               en;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] pulse_cnt;

  modport master (
    output start, stop, mode, div, burst_len,
    input  en, busy, done, pulse_cnt
  );

  modport slave (
    input  start, stop, mode, div, burst_len,
    output en, busy, done, pulse_cnt
  );

endinterface

// File: rtl/en_pulse_gen_presc_dn.sv
// Loadable down-counter used as the period prescaler; zero flags terminal count.
module presc_dn
  import en_pulse_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/en_pulse_gen.sv
// Programmable enable-pulse generator: single-cycle en strobes every div+1
// cycles, continuously or as a finite burst, with busy/done/pulse count status.
// Define EN_PULSE_GEN_ASSERTS_EN to build in the SVA checks.
module en_pulse_gen
  import en_pulse_gen_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic           clk,
  input  logic           rst_n,
  en_pulse_gen_if.slave  bus
);

  state_t             state_q, state_nxt;
  logic               en_q, done_q;
  logic [BURST_W-1:0] cnt_q, cnt_nxt;
  logic [DIV_W-1:0]   div_q;
  logic [BURST_W-1:0] len_q;
  logic               mode_q;

  logic               accept, zero_burst, finish, fire, done_nxt;
  logic               presc_load, presc_zero;
  logic [DIV_W-1:0]   presc_val;

  // The start edge itself consumes one prescaler count, so the first en
  // lands in cycle div+1 and div=0 fires straight from the start edge.
  function automatic logic [DIV_W-1:0] first_load(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  presc_dn #(.DIV_W(DIV_W)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (presc_load),
    .load_val (presc_val),
    .run      (state_q == RUN),
    .zero     (presc_zero)
  );

  // Next-state, pulse decision and counter update.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    fire       = 1'b0;
    done_nxt   = 1'b0;
    presc_load = 1'b0;
    presc_val  = div_q;

    accept     = (state_q == IDLE) && bus.start && !bus.stop;
    zero_burst = accept && (bus.mode == MODE_BURST) && (bus.burst_len == '0);
    // The final burst pulse is the one currently on en with the count at length.
    finish     = (state_q == RUN) && (mode_q == MODE_BURST) && en_q && (cnt_q == len_q);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_nxt    = '0;
          presc_load = 1'b1;
          presc_val  = first_load(bus.div);
          if (zero_burst) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            if (bus.div == '0) begin
              fire    = 1'b1;
              cnt_nxt = BURST_W'(1);
            end
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (finish) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (presc_zero) begin
          fire       = 1'b1;
          cnt_nxt    = cnt_q + BURST_W'(1);
          presc_load = 1'b1;
          presc_val  = div_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, status registers and start-time shadow copies of the settings.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_CONT;
    end else begin
      state_q <= state_nxt;
      en_q    <= fire;
      done_q  <= done_nxt;
      cnt_q   <= cnt_nxt;
      if (accept) begin
        div_q  <= bus.div;
        len_q  <= bus.burst_len;
        mode_q <= bus.mode;
      end
    end
  end

  assign bus.en        = en_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.pulse_cnt = cnt_q;

`ifdef EN_PULSE_GEN_ASSERTS_EN
  logic [DIV_W:0] gap_q;
  logic           seen_q;

  // Cycles since the previous en within the current run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      if (en_q) begin
        gap_q  <= '0;
        seen_q <= 1'b1;
      end else begin
        gap_q  <= gap_q + (DIV_W+1)'(1);
        if (state_q != RUN) seen_q <= 1'b0;
      end
    end
  end

  a_period: assert property (@(posedge clk) disable iff (!rst_n)
      en_q && seen_q |-> gap_q == {1'b0, div_q})
    else $display("%0t en_pulse_gen: en period error", $time);
  c_period: cover property (@(posedge clk) disable iff (!rst_n) en_q && seen_q);

  a_known: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({en_q, bus.busy, done_q, cnt_q}))
    else $display("%0t en_pulse_gen: unknown output", $time);
  c_known: cover property (@(posedge clk) disable iff (!rst_n) bus.busy);

  a_done: assert property (@(posedge clk) disable iff (!rst_n)
      done_q |-> $past(state_q == RUN) || $past(zero_burst))
    else $display("%0t en_pulse_gen: done without run or empty burst", $time);
  c_done: cover property (@(posedge clk) disable iff (!rst_n) done_q);

  a_en_busy: assert property (@(posedge clk) disable iff (!rst_n)
      en_q |-> state_q == RUN)
    else $display("%0t en_pulse_gen: en outside run", $time);
  c_en_busy: cover property (@(posedge clk) disable iff (!rst_n) en_q);
`endif

endmodule

// File: tb/tb_en_pulse_gen.sv
// Directed bench for en_pulse_gen: a vector table plus multi-cycle sequences.
module tb_en_pulse_gen;
  import en_pulse_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  en_pulse_gen_if #(.DIV_W(16), .BURST_W(8)) bus ();

  en_pulse_gen #(.DIV_W(16), .BURST_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] div;
    logic [7:0]  blen;
    logic        en;
    logic        busy;
    logic        done;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, input logic s, input logic p, input logic m,
                              input logic [15:0] d, input logic [7:0] l,
                              input logic e, input logic b, input logic dn, input logic [7:0] c);
    vec_t v;
    v.rst_n = r; v.start = s; v.stop = p; v.mode = m; v.div = d; v.blen = l;
    v.en = e; v.busy = b; v.done = dn; v.cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e, input int b, input int d, input int c);
    chk({tag, " en"},   int'(bus.en),        e);
    chk({tag, " busy"}, int'(bus.busy),      b);
    chk({tag, " done"}, int'(bus.done),      d);
    chk({tag, " cnt"},  int'(bus.pulse_cnt), c);
  endtask

  // Burst of four pulses at div=3 launched in cycle 0.
  task automatic run_burst1(input string tag);
    bus.div = 16'd3; bus.mode = MODE_BURST; bus.burst_len = 8'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      chk_all($sformatf("%s c%0d", tag, c),
              ((c % 4 == 0) && (c <= 16)) ? 1 : 0,
              (c <= 16) ? 1 : 0,
              (c == 17) ? 1 : 0,
              (c >= 16) ? 4 : c / 4);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = MODE_CONT;
    bus.div = '0; bus.burst_len = '0;

    // rst_n start stop mode div blen | en busy done cnt (next cycle)
    add(0, 0, 0, 0, 16'd0, 8'd0,  0, 0, 0, 8'd0);
    add(0, 1, 0, 0, 16'd0, 8'd0,  0, 0, 0, 8'd0);
    add(1, 0, 0, 0, 16'd0, 8'd0,  0, 0, 0, 8'd0);
    add(1, 1, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd0);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd0);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd0);
    add(1, 0, 0, 1, 16'd3, 8'd4,  1, 1, 0, 8'd1);
    add(1, 1, 0, 0, 16'd0, 8'd9,  0, 1, 0, 8'd1);
    add(1, 0, 0, 0, 16'd9, 8'd1,  0, 1, 0, 8'd1);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd1);
    add(1, 0, 0, 1, 16'd3, 8'd4,  1, 1, 0, 8'd2);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd2);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd2);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd2);
    add(1, 0, 0, 1, 16'd3, 8'd4,  1, 1, 0, 8'd3);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd3);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd3);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 1, 0, 8'd3);
    add(1, 0, 0, 1, 16'd3, 8'd4,  1, 1, 0, 8'd4);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 0, 1, 8'd4);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 0, 0, 8'd4);
    add(1, 0, 0, 1, 16'd3, 8'd4,  0, 0, 0, 8'd4);
    // zero-length burst: done only in the cycle after start, count cleared
    add(1, 1, 0, 1, 16'd0, 8'd0,  0, 0, 1, 8'd0);
    add(1, 0, 0, 1, 16'd0, 8'd0,  0, 0, 0, 8'd0);
    add(1, 0, 0, 1, 16'd0, 8'd0,  0, 0, 0, 8'd0);
    // start with stop in IDLE: stop wins
    add(1, 1, 1, 0, 16'd0, 8'd0,  0, 0, 0, 8'd0);
    add(1, 0, 0, 0, 16'd0, 8'd0,  0, 0, 0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n;
      bus.start = vecs[i].start; bus.stop = vecs[i].stop; bus.mode = vecs[i].mode;
      bus.div = vecs[i].div; bus.burst_len = vecs[i].blen;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].en), int'(vecs[i].busy),
              int'(vecs[i].done), int'(vecs[i].cnt));
    end
    bus.start = 1'b0; bus.stop = 1'b0;
    tick();

    // Start/stop collision held for 20 cycles.
    bus.start = 1'b1; bus.stop = 1'b1; bus.mode = MODE_CONT; bus.div = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk_all($sformatf("collide c%0d", c), 0, 0, 0, 0);
    end
    bus.start = 1'b0; bus.stop = 1'b0;
    tick();

    // Continuous div=0, stop asserted in cycle 10.
    bus.div = '0; bus.mode = MODE_CONT; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk_all($sformatf("cont c%0d", c), 1, 1, 0, c);
      if (c == 10) bus.stop = 1'b1;
      tick();
    end
    bus.stop = 1'b0;
    for (int c = 11; c <= 14; c++) begin
      chk_all($sformatf("cont c%0d", c), 0, 0, 0, 10);
      tick();
    end

    // Reset mid-burst, then a fresh burst.
    bus.div = 16'd1; bus.mode = MODE_BURST; bus.burst_len = 8'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk_all($sformatf("rstmid c%0d", c), (c % 2 == 0) ? 1 : 0, 1, 0, c / 2);
      if (c == 6) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    for (int c = 7; c <= 12; c++) begin
      chk_all($sformatf("rstmid c%0d", c), 0, 0, 0, 0);
      tick();
    end
    run_burst1("burst_after_rst");

    // Continuous div=0: count wraps at the 256th pulse; div change during RUN ignored.
    bus.div = '0; bus.mode = MODE_CONT; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 260; c++) begin
      if (c == 1) bus.div = 16'd5;
      if (c == 2) bus.start = 1'b1;
      if (c == 3) bus.start = 1'b0;
      chk($sformatf("wrap en c%0d", c), int'(bus.en), 1);
      chk($sformatf("wrap cnt c%0d", c), int'(bus.pulse_cnt), c % 256);
      if (c == 260) bus.stop = 1'b1;
      tick();
    end
    bus.stop = 1'b0;
    chk_all("wrap stopped", 0, 0, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
